// File: rtl/decode_controller.sv
// Decode stage between fetch and execute: latches one instruction, drives the immediate
// generator from the latched word and presents the decoded bundle over a valid/ready handshake.
module decode_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   output logic [24:0]      imm_region_o,
   output logic [4:0]       imm_sel_o,
   input  logic [31:0]      imm_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_imm,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic             out_funct7b5,
   output logic [1:0]       out_class,
   output logic             out_illegal,
   output logic [CNT_W-1:0] decoded_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic [1:0]  cls;
      logic        illegal;
   } bundle_t;

   state_t           state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc_q, pc_d;
   logic             out_valid_q, out_valid_d;
   bundle_t          bundle_q, bundle_d;
   logic [CNT_W-1:0] decoded_cnt_q, decoded_cnt_d;
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   logic       accept;
   logic       xfer;
   logic [1:0] dec_class;
   logic       dec_illegal;
   logic       dec_use_imm;

   assign in_ready = !reset && !flush &&
                     ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid_q && out_ready && !flush;

   // Op class from the latched word; R-ALU and unsupported opcodes carry no immediate.
   always_comb begin
      dec_class   = 2'd0;
      dec_illegal = 1'b0;
      dec_use_imm = 1'b1;
      if (instr_q[1:0] != 2'b11) begin
         dec_illegal = 1'b1;
         dec_use_imm = 1'b0;
      end else begin
         case (instr_q[6:2])
            5'b01100: dec_use_imm = 1'b0;
            5'b00100: dec_class   = 2'd1;
            5'b00000: dec_class   = 2'd2;
            5'b01000: dec_class   = 2'd3;
            default: begin
               dec_illegal = 1'b1;
               dec_use_imm = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      // NOTE: every *_d starts from its current value so no branch can infer a latch.
      state_d       = state_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      out_valid_d   = out_valid_q;
      bundle_d      = bundle_q;
      decoded_cnt_d = decoded_cnt_q;
      illegal_cnt_d = illegal_cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               instr_d = in_instr;
               pc_d    = in_pc;
               state_d = DECODE;
            end
         end
         DECODE: begin
            bundle_d.pc       = pc_q;
            bundle_d.imm      = dec_use_imm ? imm_i : 32'd0;
            bundle_d.rd       = instr_q[11:7];
            bundle_d.rs1      = instr_q[19:15];
            bundle_d.rs2      = instr_q[24:20];
            bundle_d.funct3   = instr_q[14:12];
            bundle_d.funct7b5 = instr_q[30];
            bundle_d.cls      = dec_class;
            bundle_d.illegal  = dec_illegal;
            out_valid_d       = 1'b1;
            state_d           = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (accept) begin
                  instr_d = in_instr;
                  pc_d    = in_pc;
                  state_d = DECODE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (xfer) begin
         if (decoded_cnt_q != '1) decoded_cnt_d = decoded_cnt_q + CNT_W'(1);
         if (bundle_q.illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end

      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (reset) begin
         state_q       <= IDLE;
         instr_q       <= '0;
         pc_q          <= '0;
         out_valid_q   <= 1'b0;
         bundle_q      <= '0;
         decoded_cnt_q <= '0;
         illegal_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         out_valid_q   <= out_valid_d;
         bundle_q      <= bundle_d;
         decoded_cnt_q <= decoded_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign imm_region_o = instr_q[31:7];
   assign imm_sel_o    = instr_q[6:2];
   assign out_valid    = out_valid_q;
   assign out_pc       = bundle_q.pc;
   assign out_imm      = bundle_q.imm;
   assign out_rd       = bundle_q.rd;
   assign out_rs1      = bundle_q.rs1;
   assign out_rs2      = bundle_q.rs2;
   assign out_funct3   = bundle_q.funct3;
   assign out_funct7b5 = bundle_q.funct7b5;
   assign out_class    = bundle_q.cls;
   assign out_illegal  = bundle_q.illegal;
   assign decoded_cnt  = decoded_cnt_q;
   assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_decode_controller.sv
// Directed bench for decode_controller: a default-width instance plus a CNT_W=2 instance
// driven by the same stimulus, with a small immediate-generator model on each.
module tb_decode_controller;

   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] LW   = 32'hFFC0_A103;
   localparam logic [31:0] SW   = 32'h0020_A423;
   localparam logic [31:0] ADD  = 32'h0020_81B3;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] BADQ = 32'h0050_0090;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        in_ready, out_valid, out_funct7b5, out_illegal;
   logic [24:0] imm_region_o;
   logic [4:0]  imm_sel_o, out_rd, out_rs1, out_rs2;
   logic [31:0] imm_i, out_pc, out_imm;
   logic [2:0]  out_funct3;
   logic [1:0]  out_class;
   logic [15:0] decoded_cnt, illegal_cnt;

   logic        s_in_ready, s_out_valid, s_out_funct7b5, s_out_illegal;
   logic [24:0] s_imm_region_o;
   logic [4:0]  s_imm_sel_o, s_out_rd, s_out_rs1, s_out_rs2;
   logic [31:0] s_imm_i, s_out_pc, s_out_imm;
   logic [2:0]  s_out_funct3;
   logic [1:0]  s_out_class;
   logic [1:0]  s_decoded_cnt, s_illegal_cnt;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   // Reference immediate generator; unsupported formats return a marker the DUT must drop.
   function automatic logic [31:0] imm_gen(input logic [24:0] region, input logic [4:0] sel);
      logic [31:0] w;
      w = {region, sel, 2'b11};
      case (sel)
         5'b00000, 5'b00100: return {{20{w[31]}}, w[31:20]};
         5'b01000:           return {{20{w[31]}}, w[31:25], w[11:7]};
         default:            return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign imm_i   = imm_gen(imm_region_o, imm_sel_o);
   assign s_imm_i = imm_gen(s_imm_region_o, s_imm_sel_o);

   decode_controller dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .imm_region_o(imm_region_o), .imm_sel_o(imm_sel_o), .imm_i(imm_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
      .out_funct7b5(out_funct7b5), .out_class(out_class), .out_illegal(out_illegal),
      .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
   );

   decode_controller #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .imm_region_o(s_imm_region_o), .imm_sel_o(s_imm_sel_o), .imm_i(s_imm_i),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_imm(s_out_imm),
      .out_rd(s_out_rd), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_funct3(s_out_funct3),
      .out_funct7b5(s_out_funct7b5), .out_class(s_out_class), .out_illegal(s_out_illegal),
      .decoded_cnt(s_decoded_cnt), .illegal_cnt(s_illegal_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in IDLE and take the accepting edge; DUT is in DECODE afterwards.
   task automatic accept(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      #1;
      check("in_ready_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_instr  = '0;
      in_pc     = '0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_imm_region", imm_region_o, 0);
      check("rst_imm_sel", imm_sel_o, 0);
      check("rst_out_imm", out_imm, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_decoded_cnt", decoded_cnt, 0);
      check("rst_illegal_cnt", illegal_cnt, 0);
      reset = 1'b0;
      #1;

      // addi x1,x0,5
      accept(ADDI, 32'h100);
      check("addi_dec_valid", out_valid, 0);
      check("addi_dec_ready", in_ready, 0);
      check("addi_region", imm_region_o, 25'h000A001);
      check("addi_sel", imm_sel_o, 5'b00100);
      tick();
      check("addi_valid", out_valid, 1);
      check("addi_class", out_class, 1);
      check("addi_imm", out_imm, 32'h5);
      check("addi_rd", out_rd, 1);
      check("addi_rs1", out_rs1, 0);
      check("addi_illegal", out_illegal, 0);
      check("addi_pc", out_pc, 32'h100);
      check("addi_cnt_before", decoded_cnt, 0);
      tick();
      check("addi_done_valid", out_valid, 0);
      check("addi_cnt", decoded_cnt, 1);
      check("addi_idle_ready", in_ready, 1);

      // lw x2,-4(x1)
      accept(LW, 32'h104);
      check("lw_sel", imm_sel_o, 5'b00000);
      tick();
      check("lw_imm", out_imm, 32'hFFFF_FFFC);
      check("lw_class", out_class, 2);
      check("lw_funct3", out_funct3, 3'b010);
      check("lw_rd", out_rd, 2);
      check("lw_rs1", out_rs1, 1);
      tick();
      check("lw_cnt", decoded_cnt, 2);

      // sw x2,8(x1) held by back-pressure
      out_ready = 1'b0;
      accept(SW, 32'h108);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("sw_hold_valid", out_valid, 1);
         check("sw_hold_class", out_class, 3);
         check("sw_hold_imm", out_imm, 32'h8);
         check("sw_hold_rs2", out_rs2, 2);
         check("sw_hold_in_ready", in_ready, 0);
         check("sw_hold_cnt", decoded_cnt, 2);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("sw_release_ready", in_ready, 1);
      tick();
      check("sw_cnt", decoded_cnt, 3);
      check("sw_done_valid", out_valid, 0);

      // addi then add back-to-back
      do_reset();
      in_valid = 1'b1;
      in_instr = ADDI;
      in_pc    = 32'h200;
      tick();
      in_instr = ADD;
      in_pc    = 32'h204;
      #1;
      check("b2b_dec_ready", in_ready, 0);
      tick();
      check("b2b_addi_valid", out_valid, 1);
      check("b2b_addi_class", out_class, 1);
      check("b2b_hold_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("b2b_gap_valid", out_valid, 0);
      check("b2b_gap_sel", imm_sel_o, 5'b01100);
      tick();
      check("b2b_add_valid", out_valid, 1);
      check("b2b_add_class", out_class, 0);
      check("b2b_add_imm", out_imm, 0);
      check("b2b_add_f7b5", out_funct7b5, 0);
      check("b2b_add_rd", out_rd, 3);
      check("b2b_add_rs1", out_rs1, 1);
      check("b2b_add_rs2", out_rs2, 2);
      check("b2b_add_pc", out_pc, 32'h204);
      tick();
      check("b2b_cnt", decoded_cnt, 2);

      // five jal bundles: illegal, both counters saturate in the narrow instance
      do_reset();
      for (int i = 0; i < 5; i++) begin
         accept(JAL, 32'h300 + 32'(i * 4));
         tick();
         check("jal_valid", out_valid, 1);
         check("jal_illegal", out_illegal, 1);
         check("jal_imm", out_imm, 0);
         check("jal_class", out_class, 0);
         tick();
         if (i == 0) check("jal_ill_cnt1", illegal_cnt, 1);
      end
      check("jal_dec_cnt5", decoded_cnt, 5);
      check("jal_ill_cnt5", illegal_cnt, 5);
      check("sat_dec_cnt", s_decoded_cnt, 3);
      check("sat_ill_cnt", s_illegal_cnt, 3);

      // flush during DECODE with a competing in_valid
      accept(ADDI, 32'h400);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = LW;
      #1;
      check("flush_dec_ready", in_ready, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_dec_valid", out_valid, 0);
      check("flush_dec_idle", in_ready, 1);
      tick();
      check("flush_dec_valid2", out_valid, 0);
      check("flush_dec_cnt", decoded_cnt, 5);

      // flush during HOLD with out_ready and in_valid both high
      out_ready = 1'b0;
      accept(ADDI, 32'h500);
      tick();
      check("flush_hold_pre", out_valid, 1);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = LW;
      #1;
      check("flush_hold_ready", in_ready, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_hold_valid", out_valid, 0);
      check("flush_hold_idle", in_ready, 1);
      check("flush_hold_cnt", decoded_cnt, 5);
      check("flush_hold_ill", illegal_cnt, 5);
      tick();
      check("flush_hold_valid2", out_valid, 0);

      // low opcode bits other than 2'b11 are illegal
      accept(BADQ, 32'h600);
      tick();
      check("badq_illegal", out_illegal, 1);
      check("badq_class", out_class, 0);
      check("badq_imm", out_imm, 0);
      tick();
      check("badq_ill_cnt", illegal_cnt, 6);

      // reset while a bundle is held
      out_ready = 1'b0;
      accept(SW, 32'h700);
      tick();
      check("rst_mid_pre", out_valid, 1);
      reset = 1'b1;
      tick();
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_imm", out_imm, 0);
      check("rst_mid_class", out_class, 0);
      check("rst_mid_sel", imm_sel_o, 0);
      check("rst_mid_cnt", decoded_cnt, 0);
      check("rst_mid_ready", in_ready, 0);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_mid_idle", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/decode_controller.md
# decode_controller

Sequential decode stage sitting between instruction fetch and execute in the single-cycle-derived core. It accepts an instruction word through a valid/ready handshake, latches it, and drives the immediate generator's `immediate_region`/`instruction` inputs from the latched word. It then captures the returned sign-extended immediate together with the register fields and op class, and presents the result to execute through a second valid/ready handshake. It also flags unsupported opcodes and keeps saturating decode and illegal counters.

## Interface
Parameters:
- CNT_W, 16, width of the decoded and illegal counters

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  drop any in-flight instruction; priority over all other inputs
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  controller can accept
- in_instr  in  32  instruction word
- in_pc  in  32  PC of instruction
- imm_region_o  out  25  to immediate generator: instr_q[31:7]
- imm_sel_o  out  5  to immediate generator: instr_q[6:2]
- imm_i  in  32  immediate returned combinationally by immediate generator
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  32  latched PC
- out_imm  out  32  captured immediate
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_class  out  2  0=R-ALU, 1=I-ALU, 2=LOAD, 3=STORE
- out_illegal  out  1  unsupported opcode
- decoded_cnt  out  CNT_W  bundles handed to execute, saturating
- illegal_cnt  out  CNT_W  illegal bundles handed to execute, saturating

## Operation
- States: IDLE, DECODE, HOLD.
- in_ready is combinational: 1 in IDLE, 1 in HOLD when out_ready=1, 0 in DECODE, and forced to 0 while reset or flush is high.
- IDLE: on in_valid&in_ready, latch instr_q and pc_q, then go to DECODE.
- DECODE: imm_region_o and imm_sel_o reflect instr_q. Register all out_* fields. The immediate comes from imm_i. Go to HOLD, with out_valid=1 from the next cycle.
- HOLD: out_valid=1 and all out_* fields stable until the transfer.
  - out_ready=1 with in_valid=1: latch the new instruction and go to DECODE.
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=0: stay in HOLD.
- Classification uses opcode bits [6:2] and requires instr[1:0]=2'b11:
  - 01100 is R-ALU; out_imm is forced to 0.
  - 00100 is I-ALU.
  - 00000 is LOAD.
  - 01000 is STORE.
  - Any other value: out_illegal=1, out_class=0, out_imm=0.
- Counters increment on each out_valid&out_ready. illegal_cnt increments only when out_illegal=1. Both saturate at all-ones and never wrap.
- flush: next state is IDLE, out_valid drops to 0 on the next edge, and the latched instruction is discarded. An in_valid in the same cycle is not accepted. Counters are unaffected.

## Timing
- Reset values:
  - state is IDLE.
  - out_valid and in_ready are 0.
  - instr_q, pc_q, all out_* fields and both counters are 0.
  - imm_region_o and imm_sel_o are 0.
- Latency: accept at edge N, DECODE during cycle N+1, out_valid high in cycle N+2.
- Throughput: one instruction per 2 cycles under continuous valid/ready.
- imm_i is sampled only at the DECODE→HOLD edge. The immediate generator path must settle within one cycle.
- imm_region_o and imm_sel_o are driven from registers and hold their value outside DECODE.
- out_* fields change only at the DECODE→HOLD edge or on reset.
- Reset asserted mid-operation: everything returns to reset values on the next edge. The pending bundle is lost.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1: out_valid in the 2nd cycle after accept, with class=1, imm=0x00000005, rd=1, rs1=0, illegal=0.
- lw x2,-4(x1) (0xFFC0A103): imm_sel_o=00000, out_imm=0xFFFFFFFC, class=2, funct3=010.
- sw x2,8(x1) (0x0020A423) with out_ready held 0 for 5 cycles: bundle (class=3, imm=0x00000008, rs2=2) stays stable, in_ready stays 0, and decoded_cnt increments once after release.
- add x3,x1,x2 (0x002081B3) back-to-back with addi: bundles 2 cycles apart, R-ALU has imm=0 and funct7b5=0, decoded_cnt=2.
- jal (0x0000006F): out_illegal=1, out_imm=0, illegal_cnt=1; with CNT_W=2, five illegal bundles leave both counters saturated at 3.
- flush asserted in DECODE and again in HOLD: out_valid=0 the next cycle, state is IDLE, counters unchanged, and a concurrent in_valid is not accepted.
